// File: rtl/axi_mst_pkg.sv
// Shared AXI constants, FSM state type and size helper for axi_burst_master.
package axi_mst_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RADDR,
    ST_RDATA,
    ST_WADDR,
    ST_WDATA,
    ST_WRESP,
    ST_DONE
  } state_e;

  function automatic logic [2:0] size_from_width(input int unsigned data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 INCR burst initiator driven by a native request port.
// Optional 4 KB page-crossing rejection enabled by defining AXI_MST_4K_CHECK_EN.
//
// state    | meaning
// IDLE     | req_ready high, waiting for a request
// RADDR    | arvalid held until arready
// RDATA    | R beats passed through to the requester, counted to len
// WADDR    | awvalid held until awready
// WDATA    | requester beats passed through to W, wlast on beat len
// WRESP    | bready high until the write response arrives
// DONE     | one-cycle done/done_err pulse, then back to IDLE
module axi_burst_master
  import axi_mst_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 8,
  parameter logic [ID_W-1:0] MST_ID = '0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [LEN_W-1:0]    req_len,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_strb,
  input  logic                wr_valid,
  output logic                wr_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_last,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic                done,
  output logic                done_err,
  output logic [ID_W-1:0]     awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [LEN_W-1:0]    awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [ID_W-1:0]     bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic [ID_W-1:0]     arid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [LEN_W-1:0]    arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arvalid,
  input  logic                arready,
  input  logic [ID_W-1:0]     rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready
);

  localparam int         STRB_W = DATA_W / 8;
  localparam logic [2:0] AXSIZE = size_from_width(DATA_W);

  state_e            state;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic              err_q;
  logic              req_ready_q;
  logic              awvalid_q;
  logic              arvalid_q;
  logic              bready_q;
  logic              done_q;
  logic              done_err_q;

  logic accept;
  logic w_hs;
  logic r_hs;
  logic cnt_last;
  logic r_err;
  logic cross_4k;

  assign accept   = req_valid && req_ready_q;
  assign cnt_last = (cnt_q == len_q);
  assign w_hs     = (state == ST_WDATA) && wr_valid && wready;
  assign r_hs     = (state == ST_RDATA) && rvalid && rd_ready;
  // A beat is bad if the slave flags it or its rlast disagrees with our count.
  assign r_err    = (rresp != RESP_OKAY) || (rlast != cnt_last);

`ifdef AXI_MST_4K_CHECK_EN
  logic [ADDR_W:0] last_byte;
  assign last_byte = {1'b0, req_addr}
                   + (ADDR_W+1)'((32'(req_len) + 32'd1) * 32'(STRB_W))
                   - (ADDR_W+1)'(1);
  assign cross_4k  = (last_byte[ADDR_W:12] != {1'b0, req_addr[ADDR_W-1:12]});
`else
  assign cross_4k  = 1'b0;
`endif

  assign req_ready = req_ready_q;
  assign done      = done_q;
  assign done_err  = done_err_q;

  assign awid    = MST_ID;
  assign awaddr  = addr_q;
  assign awlen   = len_q;
  assign awsize  = AXSIZE;
  assign awburst = BURST_INCR;
  assign awvalid = awvalid_q;

  assign arid    = MST_ID;
  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arsize  = AXSIZE;
  assign arburst = BURST_INCR;
  assign arvalid = arvalid_q;

  assign wdata    = wr_data;
  assign wstrb    = wr_strb;
  assign wvalid   = (state == ST_WDATA) && wr_valid;
  assign wr_ready = (state == ST_WDATA) && wready;
  assign wlast    = (state == ST_WDATA) && cnt_last;

  assign rd_data  = rdata;
  assign rd_last  = rlast;
  assign rd_valid = (state == ST_RDATA) && rvalid;
  assign rready   = (state == ST_RDATA) && rd_ready;

  assign bready = bready_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      done_q      <= 1'b0;
      done_err_q  <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          req_ready_q <= 1'b1;
          if (accept) begin
            req_ready_q <= 1'b0;
            addr_q      <= req_addr;
            len_q       <= req_len;
            cnt_q       <= '0;
            if (cross_4k) begin
              state      <= ST_DONE;
              done_q     <= 1'b1;
              done_err_q <= 1'b1;
            end else if (req_we) begin
              state     <= ST_WADDR;
              awvalid_q <= 1'b1;
            end else begin
              state     <= ST_RADDR;
              arvalid_q <= 1'b1;
            end
          end
        end
        ST_WADDR: begin
          if (awready) begin
            awvalid_q <= 1'b0;
            state     <= ST_WDATA;
          end
        end
        ST_WDATA: begin
          if (w_hs) begin
            if (cnt_last) begin
              state    <= ST_WRESP;
              bready_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + LEN_W'(1);
            end
          end
        end
        ST_WRESP: begin
          if (bvalid) begin
            bready_q   <= 1'b0;
            state      <= ST_DONE;
            done_q     <= 1'b1;
            done_err_q <= err_q || (bresp != RESP_OKAY);
          end
        end
        ST_RADDR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            state     <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          // The burst is drained to len+1 beats even after an error.
          if (r_hs) begin
            if (r_err) err_q <= 1'b1;
            if (cnt_last) begin
              state      <= ST_DONE;
              done_q     <= 1'b1;
              done_err_q <= err_q || r_err;
            end else begin
              cnt_q <= cnt_q + LEN_W'(1);
            end
          end
        end
        ST_DONE: begin
          state       <= ST_IDLE;
          err_q       <= 1'b0;
          cnt_q       <= '0;
          req_ready_q <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_burst_master.md
Name: axi_burst_master

Overview:
- AXI4 initiator that converts a native single-request interface into one INCR burst on the AW/W/B or AR/R channels.
- It is the counterpart of the memory-side AXI slave wrappers: it sits between a requester (cache refill, DMA, core bus bridge) and the interconnect master port.
- One transaction is outstanding at a time; write data and read data are streamed with valid/ready.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; must be a power of two ≥ 8
- ID_W, 4, AXI ID width
- LEN_W, 8, AXI burst length width
- MST_ID, 0, constant value driven on awid/arid

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid&&req_ready
req_we  in  1  1=write burst, 0=read burst
req_addr  in  ADDR_W  start byte address, size-aligned
req_len  in  LEN_W  beats-1 (AXI encoding)
wr_data  in  DATA_W  write beat data
wr_strb  in  DATA_W/8  write byte strobes
wr_valid  in  1  write beat valid
wr_ready  out  1  write beat consumed
rd_data  out  DATA_W  read beat data
rd_last  out  1  final read beat
rd_valid  out  1  read beat valid
rd_ready  in  1  read beat accepted
done  out  1  one-cycle pulse at transaction end
done_err  out  1  valid with done; 1 = any non-OKAY resp or protocol mismatch
awid/awaddr/awlen/awsize/awburst/awvalid/awready, wdata/wstrb/wlast/wvalid/wready, bid/bresp/bvalid/bready, arid/araddr/arlen/arsize/arburst/arvalid/arready, rid/rdata/rresp/rlast/rvalid/rready: standard AXI4 master-side directions, widths per parameters (awsize/arsize 3 bits, burst/resp 2 bits)

Behaviour:
- Reset (rst_ni=0 on clk_i edge): state IDLE; all valids low (awvalid, wvalid, arvalid, rd_valid, done); bready=0; rready=0; req_ready=0; beat counter 0; err flag 0.
- FSM states: IDLE, RADDR, RDATA, WADDR, WDATA, WRESP, DONE.
  - IDLE: req_ready=1. On accept, latch addr/len/we and go to WADDR (we=1) or RADDR.
- Address phase: awaddr/araddr = latched addr; awlen/arlen = len; size = log2(DATA_W/8); burst = 2'b01 (INCR); id = MST_ID. Valid rises the cycle after accept and holds with stable payload until ready.
- RDATA:
  - rready=rd_ready and rd_valid=rvalid (pass-through, zero latency); rd_data=rdata; rd_last=rlast.
  - Counter increments per handshake.
  - Error conditions: rresp≠OKAY on any beat; rlast=1 before counter==len; rlast=0 when counter==len. Each sets the sticky err flag.
  - Exit to DONE on the beat where counter==len; the burst is always drained to len+1 beats.
- WDATA:
  - wvalid=wr_valid, wr_ready=wready; wdata/wstrb pass-through.
  - wlast=1 iff counter==len.
  - After the last beat handshake go to WRESP.
  - W is never driven before AW has handshaked.
- WRESP: bready=1. On bvalid, set err if bresp≠OKAY, then go to DONE.
- DONE: done=1 and done_err=err for one cycle, then clear err and counter and return to IDLE. Earliest next accept is the cycle after DONE.
- len=0: single beat; wlast/rd_last asserted on the first beat.
- rid/bid are not checked against MST_ID.
- Reset mid-burst: abandons the transaction immediately. The requester must not reset independently of the interconnect.

Optional Feature:
- Macro: AXI_MST_4K_CHECK_EN.
- Defined:
  - In IDLE, a request whose last byte (addr + (len+1)·DATA_W/8 − 1) lies in a different 4 KB page than addr is accepted but not issued.
  - The block goes directly to DONE with done_err=1. No AXI valids are asserted, and for writes no wr_ready is asserted.
- Undefined: no check; the request is issued as given (requester is responsible).

Decomposition:
- Shared package axi_mst_pkg holds:
  - AXI constants: BURST_INCR=2'b01; RESP_OKAY/EXOKAY/SLVERR/DECERR.
  - The state enum type.
  - A size-from-width function.
- No sub-module; single FSM plus beat counter.

Test Plan:
- Read, addr=0x100, len=3, slave returns 4 beats OKAY with rlast on beat 4 -> araddr=0x100, arlen=3, arsize=2, arburst=1; 4 rd beats with rd_last on the 4th; done=1, done_err=0.
- Write, addr=0x200, len=1, data A5A5A5A5/5A5A5A5A, strb F/3 -> wlast only on beat 2; bready until bvalid; bresp=OKAY gives done_err=0.
- Backpressure: awready delayed 5 cycles, rready toggled by rd_ready every other cycle -> awaddr stable while awvalid; no beat lost or duplicated.
- Errors:
  - rresp=SLVERR on beat 2 of 4 -> all 4 beats still forwarded; done_err=1.
  - Early rlast on beat 2 of 4 -> done_err=1.
  - bresp=DECERR -> done_err=1.
- len=0 write and read -> single beat carries wlast=1 / rd_last=1; done follows.
- With AXI_MST_4K_CHECK_EN: addr=0xFF8, len=3, DATA_W=32 -> no awvalid/arvalid; done_err=1. Same request without the macro -> issued normally.
